// File: rtl/dm_bigint_adder.sv
// Multi-precision adder that masters the data-memory port: R = A + B over WORDS little-endian words.
// Optional subtract mode (R = A - B, adds port `sub`) is enabled by defining DM_BIGINT_SUB_EN.
module dm_bigint_adder #(
   parameter int AW    = 8,
   parameter int DW    = 16,
   parameter int WORDS = 4
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          start,
`ifdef DM_BIGINT_SUB_EN
   input  logic          sub,
`endif
   input  logic [AW-1:0] base_a,
   input  logic [AW-1:0] base_b,
   input  logic [AW-1:0] base_r,
   output logic          busy,
   output logic          done,
   output logic          carry_out,
   output logic [AW-1:0] mem_addr,
   output logic [DW-1:0] mem_din,
   input  logic [DW-1:0] mem_dout,
   output logic          mem_we
);

   typedef enum logic [2:0] {
      S_IDLE = 3'd0,
      S_RD_A = 3'd1,
      S_RD_B = 3'd2,
      S_WR   = 3'd3,
      S_DONE = 3'd4
   } state_t;

   localparam logic [7:0] LAST_IDX = 8'(WORDS - 1);

   // Word address: base plus index, wrapping modulo 2^AW.
   function automatic logic [AW-1:0] word_addr(input logic [AW-1:0] base, input logic [7:0] idx);
      return base + AW'(idx);
   endfunction

   // One word of the ripple: {carry, sum} of a + b + cin.
   function automatic logic [DW:0] add_word(input logic [DW-1:0] a, input logic [DW-1:0] b,
                                            input logic cin);
      return {1'b0, a} + {1'b0, b} + {{DW{1'b0}}, cin};
   endfunction

   state_t        state_r, state_s;
   logic [7:0]    idx_r, idx_s;
   logic          carry_r, carry_s;
   logic [DW-1:0] a_reg_r, a_reg_s;
   logic [AW-1:0] base_a_r, base_a_s;
   logic [AW-1:0] base_b_r, base_b_s;
   logic [AW-1:0] base_r_r, base_r_s;
   logic [AW-1:0] mem_addr_r, mem_addr_s;
   logic [DW-1:0] mem_din_r, mem_din_s;
   logic          mem_we_r, mem_we_s;
   logic          busy_r, busy_s;
   logic          done_r, done_s;
   logic          carry_out_r, carry_out_s;
   logic [DW-1:0] b_op_s;
   logic          cin_init_s;
   logic [DW:0]   sum_s;
`ifdef DM_BIGINT_SUB_EN
   logic          sub_r, sub_s;
`endif

   // Operand B conditioning and initial carry; subtract is A + ~B + 1.
   always_comb begin
`ifdef DM_BIGINT_SUB_EN
      if (sub_r) begin
         b_op_s = ~mem_dout;
      end else begin
         b_op_s = mem_dout;
      end
      if (sub) begin
         cin_init_s = 1'b1;
      end else begin
         cin_init_s = 1'b0;
      end
`else
      b_op_s     = mem_dout;
      cin_init_s = 1'b0;
`endif
   end

   // Next-state and next-output logic; mem_addr is loaded one state ahead so the
   // combinational DM read returns the wanted word during the state that uses it.
   always_comb begin
      state_s     = state_r;
      idx_s       = idx_r;
      carry_s     = carry_r;
      a_reg_s     = a_reg_r;
      base_a_s    = base_a_r;
      base_b_s    = base_b_r;
      base_r_s    = base_r_r;
      mem_addr_s  = mem_addr_r;
      mem_din_s   = mem_din_r;
      mem_we_s    = 1'b0;
      busy_s      = busy_r;
      done_s      = 1'b0;
      carry_out_s = carry_out_r;
      sum_s       = {(DW+1){1'b0}};
`ifdef DM_BIGINT_SUB_EN
      sub_s       = sub_r;
`endif
      case (state_r)
         S_IDLE: begin
            if (start) begin
               base_a_s   = base_a;
               base_b_s   = base_b;
               base_r_s   = base_r;
               idx_s      = 8'd0;
               carry_s    = cin_init_s;
               mem_addr_s = base_a;
               busy_s     = 1'b1;
               state_s    = S_RD_A;
`ifdef DM_BIGINT_SUB_EN
               sub_s      = sub;
`endif
            end else begin
               state_s = S_IDLE;
            end
         end
         S_RD_A: begin
            a_reg_s    = mem_dout;
            mem_addr_s = word_addr(base_b_r, idx_r);
            state_s    = S_RD_B;
         end
         S_RD_B: begin
            sum_s      = add_word(a_reg_r, b_op_s, carry_r);
            carry_s    = sum_s[DW];
            mem_din_s  = sum_s[DW-1:0];
            mem_addr_s = word_addr(base_r_r, idx_r);
            mem_we_s   = 1'b1;
            state_s    = S_WR;
         end
         S_WR: begin
            if (idx_r == LAST_IDX) begin
               state_s = S_DONE;
            end else begin
               idx_s      = idx_r + 8'd1;
               mem_addr_s = word_addr(base_a_r, idx_r + 8'd1);
               state_s    = S_RD_A;
            end
         end
         S_DONE: begin
            done_s      = 1'b1;
            carry_out_s = carry_r;
            busy_s      = 1'b0;
            state_s     = S_IDLE;
         end
         default: begin
            busy_s  = 1'b0;
            state_s = S_IDLE;
         end
      endcase
   end

   // State and output registers with synchronous reset.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_r     <= S_IDLE;
         idx_r       <= 8'd0;
         carry_r     <= 1'b0;
         a_reg_r     <= {DW{1'b0}};
         base_a_r    <= {AW{1'b0}};
         base_b_r    <= {AW{1'b0}};
         base_r_r    <= {AW{1'b0}};
         mem_addr_r  <= {AW{1'b0}};
         mem_din_r   <= {DW{1'b0}};
         mem_we_r    <= 1'b0;
         busy_r      <= 1'b0;
         done_r      <= 1'b0;
         carry_out_r <= 1'b0;
`ifdef DM_BIGINT_SUB_EN
         sub_r       <= 1'b0;
`endif
      end else begin
         state_r     <= state_s;
         idx_r       <= idx_s;
         carry_r     <= carry_s;
         a_reg_r     <= a_reg_s;
         base_a_r    <= base_a_s;
         base_b_r    <= base_b_s;
         base_r_r    <= base_r_s;
         mem_addr_r  <= mem_addr_s;
         mem_din_r   <= mem_din_s;
         mem_we_r    <= mem_we_s;
         busy_r      <= busy_s;
         done_r      <= done_s;
         carry_out_r <= carry_out_s;
`ifdef DM_BIGINT_SUB_EN
         sub_r       <= sub_s;
`endif
      end
   end

   assign busy      = busy_r;
   assign done      = done_r;
   assign carry_out = carry_out_r;
   assign mem_addr  = mem_addr_r;
   assign mem_din   = mem_din_r;
   // Reset kills a write already in flight so an abort never lands another word.
   assign mem_we    = mem_we_r & ~reset;

endmodule

// File: tb/tb_dm_bigint_adder.sv
// Scoreboard bench for dm_bigint_adder: expected DM writes and done/carry events are
// queued at stimulus time and checked by an independent monitor on the falling edge.
module tb_dm_bigint_adder;
   localparam int AW = 8;
   localparam int DW = 16;
   localparam int WORDS = 4;

   logic          clk = 1'b0;
   logic          reset;
   logic          start;
   logic          sub;
   logic [AW-1:0] base_a, base_b, base_r;
   logic          busy, done, carry_out;
   logic [AW-1:0] mem_addr;
   logic [DW-1:0] mem_din, mem_dout;
   logic          mem_we;

   logic [DW-1:0] dm [0:255];
   logic          tb_we;
   logic [AW-1:0] tb_addr;
   logic [DW-1:0] tb_din;

   int cyc = 0;
   int n_checks = 0;
   int n_fail = 0;

   logic [AW+DW-1:0] wr_q[$];
   logic             exp_c_q[$];
   int               exp_t_q[$];

   dm_bigint_adder #(.AW(AW), .DW(DW), .WORDS(WORDS)) dut (
      .clk(clk), .reset(reset), .start(start),
`ifdef DM_BIGINT_SUB_EN
      .sub(sub),
`endif
      .base_a(base_a), .base_b(base_b), .base_r(base_r),
      .busy(busy), .done(done), .carry_out(carry_out),
      .mem_addr(mem_addr), .mem_din(mem_din), .mem_dout(mem_dout), .mem_we(mem_we)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   // Data memory model: combinational read, write on posedge; bench preload port when DUT is quiet.
   assign mem_dout = dm[mem_addr];
   always @(posedge clk) begin
      if (mem_we) dm[mem_addr] <= mem_din;
      else if (tb_we) dm[tb_addr] <= tb_din;
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h, required %h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // Monitor: every DM write and every done pulse must match the head of its queue.
   always @(negedge clk) begin
      logic [AW+DW-1:0] e;
      if (mem_we === 1'b1) begin
         if (wr_q.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL unexpected_write: got addr %h data %h, required no write", mem_addr, mem_din);
         end else begin
            e = wr_q.pop_front();
            check("wr_addr", 32'(mem_addr), 32'(e[AW+DW-1:DW]));
            check("wr_data", 32'(mem_din), 32'(e[DW-1:0]));
         end
      end
      if (done === 1'b1) begin
         if (exp_c_q.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL unexpected_done: got done=1, required done=0 (cycle %0d)", cyc);
         end else begin
            check("carry_out", 32'(carry_out), 32'(exp_c_q.pop_front()));
            check("done_cycle", 32'(cyc), 32'(exp_t_q.pop_front()));
            check("busy_at_done", 32'(busy), 32'd0);
         end
      end
   end

   task automatic load(input logic [AW-1:0] a, input logic [DW-1:0] d);
      tb_addr = a;
      tb_din  = d;
      tb_we   = 1'b1;
      @(posedge clk); #1;
      tb_we   = 1'b0;
   endtask

   task automatic exp_wr(input logic [AW-1:0] a, input logic [DW-1:0] d);
      wr_q.push_back({a, d});
   endtask

   // Issue start (called 1 time unit after a posedge); done is due 3*WORDS+1 edges after acceptance.
   task automatic go(input logic [AW-1:0] a, input logic [AW-1:0] b, input logic [AW-1:0] r,
                     input logic s, input logic c);
      start  = 1'b1;
      base_a = a;
      base_b = b;
      base_r = r;
      sub    = s;
      exp_c_q.push_back(c);
      exp_t_q.push_back(cyc + 3*WORDS + 2);
      @(posedge clk); #1;
      start  = 1'b0;
   endtask

   task automatic drain(input string name);
      for (int i = 0; i < 200; i++) begin
         @(posedge clk); #1;
         if (wr_q.size() == 0 && exp_c_q.size() == 0) break;
      end
      check(name, 32'(wr_q.size() + exp_c_q.size()), 32'd0);
   endtask

   initial begin
      #200000;
      $display("FAIL global_timeout: simulation did not finish, required finish");
      $fatal(1);
   end

   initial begin
      reset = 1'b1; start = 1'b0; sub = 1'b0; tb_we = 1'b0;
      base_a = '0; base_b = '0; base_r = '0; tb_addr = '0; tb_din = '0;
      repeat (3) @(posedge clk);
      #1;
      reset = 1'b0;
      @(posedge clk); #1;
      check("rst_busy", 32'(busy), 32'd0);
      check("rst_done", 32'(done), 32'd0);
      check("rst_carry_out", 32'(carry_out), 32'd0);
      check("rst_mem_we", 32'(mem_we), 32'd0);
      check("rst_mem_addr", 32'(mem_addr), 32'd0);
      check("rst_mem_din", 32'(mem_din), 32'd0);

      // Scenario 1: carry ripple, exact latency.
      load(8'h00, 16'hfffe); load(8'h01, 16'hfffe); load(8'h02, 16'hfffe); load(8'h03, 16'h0000);
      load(8'h04, 16'hffff); load(8'h05, 16'hffff); load(8'h06, 16'hffff); load(8'h07, 16'h0000);
      exp_wr(8'h08, 16'hfffd); exp_wr(8'h09, 16'hfffe); exp_wr(8'h0a, 16'hfffe); exp_wr(8'h0b, 16'h0001);
      go(8'h00, 8'h04, 8'h08, 1'b0, 1'b0);
      drain("drain_s1");
      check("s1_busy_after", 32'(busy), 32'd0);
      check("s1_dm11", 32'(dm[11]), 32'h0001);

      // Scenario 2: wrap-around carry out of the top word.
      load(8'h30, 16'hffff); load(8'h31, 16'hffff); load(8'h32, 16'hffff); load(8'h33, 16'hffff);
      load(8'h34, 16'h0001); load(8'h35, 16'h0000); load(8'h36, 16'h0000); load(8'h37, 16'h0000);
      load(8'h38, 16'h5555); load(8'h39, 16'h5555); load(8'h3a, 16'h5555); load(8'h3b, 16'h5555);
      exp_wr(8'h38, 16'h0000); exp_wr(8'h39, 16'h0000); exp_wr(8'h3a, 16'h0000); exp_wr(8'h3b, 16'h0000);
      go(8'h30, 8'h34, 8'h38, 1'b0, 1'b1);
      drain("drain_s2");

      // Scenario 4: reset during the second WR cycle aborts with no further writes.
      load(8'h08, 16'haaaa); load(8'h09, 16'haaaa); load(8'h0a, 16'haaaa); load(8'h0b, 16'haaaa);
      check("carry_hold", 32'(carry_out), 32'd1);
      exp_wr(8'h08, 16'hfffd);
      start = 1'b1; base_a = 8'h00; base_b = 8'h04; base_r = 8'h08; sub = 1'b0;
      @(posedge clk); #1;
      start = 1'b0;
      repeat (5) @(posedge clk);
      #1;
      check("s4_we_in_wr2", 32'(mem_we), 32'd1);
      check("s4_addr_in_wr2", 32'(mem_addr), 32'h09);
      reset = 1'b1;
      @(posedge clk); #1;
      check("s4_we_after_rst", 32'(mem_we), 32'd0);
      check("s4_busy_after_rst", 32'(busy), 32'd0);
      check("s4_carry_after_rst", 32'(carry_out), 32'd0);
      reset = 1'b0;
      repeat (20) @(posedge clk);
      #1;
      check("s4_dm8", 32'(dm[8]), 32'hfffd);
      check("s4_dm9", 32'(dm[9]), 32'haaaa);
      check("s4_pending_writes", 32'(wr_q.size()), 32'd0);

      // Scenario 3: in-place, result overwrites operand A.
      load(8'h00, 16'hfffe); load(8'h01, 16'hfffe); load(8'h02, 16'hfffe); load(8'h03, 16'h0000);
      exp_wr(8'h00, 16'hfffd); exp_wr(8'h01, 16'hfffe); exp_wr(8'h02, 16'hfffe); exp_wr(8'h03, 16'h0001);
      go(8'h00, 8'h04, 8'h00, 1'b0, 1'b0);
      drain("drain_s3");
      check("s3_dm4", 32'(dm[4]), 32'hffff);
      check("s3_dm5", 32'(dm[5]), 32'hffff);
      check("s3_dm6", 32'(dm[6]), 32'hffff);
      check("s3_dm7", 32'(dm[7]), 32'h0000);

      // Scenario 5: address wrap on A, second start while busy ignored.
      load(8'hfe, 16'h1111); load(8'hff, 16'h2222); load(8'h00, 16'h3333); load(8'h01, 16'h4444);
      load(8'h10, 16'h0001); load(8'h11, 16'h0002); load(8'h12, 16'h0003); load(8'h13, 16'h0004);
      exp_wr(8'h20, 16'h1112); exp_wr(8'h21, 16'h2224); exp_wr(8'h22, 16'h3336); exp_wr(8'h23, 16'h4448);
      go(8'hfe, 8'h10, 8'h20, 1'b0, 1'b0);
      repeat (2) @(posedge clk);
      #1;
      start = 1'b1; base_a = 8'h40; base_b = 8'h50; base_r = 8'h60;
      @(posedge clk); #1;
      start = 1'b0;
      drain("drain_s5");
      repeat (10) @(posedge clk);
      #1;
      check("s5_idle_busy", 32'(busy), 32'd0);

`ifdef DM_BIGINT_SUB_EN
      // Scenario 6: subtract with borrow.
      load(8'h00, 16'hfffe); load(8'h01, 16'hfffe); load(8'h02, 16'hfffe); load(8'h03, 16'h0000);
      exp_wr(8'h08, 16'hffff); exp_wr(8'h09, 16'hfffe); exp_wr(8'h0a, 16'hfffe); exp_wr(8'h0b, 16'hffff);
      go(8'h00, 8'h04, 8'h08, 1'b1, 1'b0);
      drain("drain_s6");
`endif

      check("final_queues", 32'(wr_q.size() + exp_c_q.size()), 32'd0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
